// File: rtl/mastermind_solver_pkg.sv
// Shared types and widths for the Mastermind code-breaker and its scorer.
package mastermind_pkg;
    localparam int PEG_W    = 3;
    localparam int NUM_PEGS = 4;
    localparam int CODE_W   = PEG_W * NUM_PEGS;

    typedef enum logic [2:0] {
        IDLE,
        OFFER,
        WAIT_FB,
        SEARCH,
        SOLVED,
        FAIL
    } state_t;

    typedef struct packed {
        logic [2:0] red;
        logic [2:0] white;
    } feedback_t;
endpackage

// File: rtl/mastermind_solver_if.sv
// Guess/feedback exchange between the code-breaker (master) and the scorer (slave).
interface mastermind_solver_if
    import mastermind_pkg::*;
();
    logic [CODE_W-1:0] guess;
    logic              guess_valid;
    logic              guess_ready;
    logic              fb_valid;
    logic [2:0]        fb_red;
    logic [2:0]        fb_white;

    modport master (
        output guess, guess_valid,
        input  guess_ready, fb_valid, fb_red, fb_white
    );

    modport slave (
        input  guess, guess_valid,
        output guess_ready, fb_valid, fb_red, fb_white
    );
endinterface

// File: rtl/mastermind_solver_score.sv
// Combinational Mastermind scorer: red = exact matches, white = colour matches minus red.
module mastermind_score
    import mastermind_pkg::*;
(
    input  logic [CODE_W-1:0] a,
    input  logic [CODE_W-1:0] b,
    output logic [2:0]        red,
    output logic [2:0]        white
);
    logic [2:0] red_sum;
    logic [2:0] min_sum;
    logic [2:0] cnt_a;
    logic [2:0] cnt_b;

    always_comb begin
        // NOTE: every variable gets a default before use so no latch is inferred;
        // blocking assignments let the loop accumulate within one evaluation.
        red_sum = '0;
        min_sum = '0;
        cnt_a   = '0;
        cnt_b   = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            red_sum = red_sum + 3'(a[i*PEG_W +: PEG_W] == b[i*PEG_W +: PEG_W]);
        end
        for (int c = 0; c < 8; c++) begin
            cnt_a = '0;
            cnt_b = '0;
            for (int i = 0; i < NUM_PEGS; i++) begin
                cnt_a = cnt_a + 3'(a[i*PEG_W +: PEG_W] == 3'(c));
                cnt_b = cnt_b + 3'(b[i*PEG_W +: PEG_W] == 3'(c));
            end
            min_sum = min_sum + ((cnt_a < cnt_b) ? cnt_a : cnt_b);
        end
    end

    assign red   = red_sum;
    assign white = min_sum - red_sum;
endmodule

// File: rtl/mastermind_solver.sv
// Mastermind code-breaker: offers guesses, records feedback, searches the next consistent code.
// Optional MASTERMIND_SOLVER_STATS_EN adds a saturating per-game SEARCH cycle counter.
module mastermind_solver
    import mastermind_pkg::*;
#(
    parameter int                MAX_GUESSES = 10,
    parameter logic [CODE_W-1:0] INIT_GUESS  = 12'o0011
)(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    mastermind_solver_if.master bus,
    output logic                busy,
    output logic                solved,
    output logic                fail,
    output logic [3:0]          guess_count
`ifdef MASTERMIND_SOLVER_STATS_EN
    ,
    output logic [15:0]         search_cycles
`endif
);
    state_t            state;
    logic [3:0]        n;
    logic [3:0]        h;
    logic [CODE_W-1:0] cand;
    logic [CODE_W-1:0] hist_guess [MAX_GUESSES];
    feedback_t         hist_fb    [MAX_GUESSES];
    logic [CODE_W-1:0] hist_sel;
    logic [2:0]        cand_red;
    logic [2:0]        cand_white;
    logic [3:0]        fb_sum;
    logic              game_start;
    logic              accept;
    logic              fb_take;

    assign game_start = start && (state inside {IDLE, SOLVED, FAIL});
    assign accept     = (state == OFFER) && bus.guess_ready;
    assign fb_take    = (state == WAIT_FB) && bus.fb_valid;
    assign fb_sum     = {1'b0, bus.fb_red} + {1'b0, bus.fb_white};
    assign hist_sel   = hist_guess[h];

    mastermind_score u_score (
        .a     (cand),
        .b     (hist_sel),
        .red   (cand_red),
        .white (cand_white)
    );

    // NOTE: the history is plain storage with no reset; entries beyond n are never read.
    always_ff @(posedge clock) begin
        if (accept)  hist_guess[n] <= bus.guess;
        if (fb_take) hist_fb[n]    <= '{red: bus.fb_red, white: bus.fb_white};
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            bus.guess       <= '0;
            bus.guess_valid <= 1'b0;
            busy            <= 1'b0;
            solved          <= 1'b0;
            fail            <= 1'b0;
            guess_count     <= '0;
            n               <= '0;
            h               <= '0;
            cand            <= '0;
        end else begin
            unique case (state)
                IDLE, SOLVED, FAIL: begin
                    if (start) begin
                        state           <= OFFER;
                        bus.guess       <= INIT_GUESS;
                        bus.guess_valid <= 1'b1;
                        busy            <= 1'b1;
                        solved          <= 1'b0;
                        fail            <= 1'b0;
                        guess_count     <= '0;
                        n               <= '0;
                        cand            <= '0;
                    end
                end
                OFFER: begin
                    if (bus.guess_ready) begin
                        state           <= WAIT_FB;
                        bus.guess_valid <= 1'b0;
                        guess_count     <= guess_count + 4'd1;
                    end
                end
                WAIT_FB: begin
                    if (bus.fb_valid) begin
                        n <= n + 4'd1;
                        h <= '0;
                        if (bus.fb_red == 3'd4) begin
                            state  <= SOLVED;
                            busy   <= 1'b0;
                            solved <= 1'b1;
                        end else if (fb_sum > 4'd4 || guess_count == 4'(MAX_GUESSES)) begin
                            state <= FAIL;
                            busy  <= 1'b0;
                            fail  <= 1'b1;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    // Constraints only accumulate, so the pointer never needs to rewind.
                    if (h == n) begin
                        state           <= OFFER;
                        bus.guess       <= cand;
                        bus.guess_valid <= 1'b1;
                        cand            <= cand + 12'd1;
                    end else if ({cand_red, cand_white} != hist_fb[h]) begin
                        if (cand == '1) begin
                            state <= FAIL;
                            busy  <= 1'b0;
                            fail  <= 1'b1;
                        end else begin
                            cand <= cand + 12'd1;
                            h    <= '0;
                        end
                    end else begin
                        h <= h + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MASTERMIND_SOLVER_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            search_cycles <= '0;
        end else if (game_start) begin
            search_cycles <= '0;
        end else if (state == SEARCH && search_cycles != 16'hFFFF) begin
            search_cycles <= search_cycles + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mastermind_solver.sv
// Self-checking bench for mastermind_solver: scorer vectors, scripted games, random games vs a model.
module tb_mastermind_solver;
    import mastermind_pkg::*;

    localparam int          MAX_G = 10;
    localparam logic [11:0] INIT  = 12'o0011;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [2:0]  red;
        logic [2:0]  white;
    } score_vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        solved;
    logic        fail;
    logic [3:0]  guess_count;
    logic [11:0] sa;
    logic [11:0] sb;
    logic [2:0]  s_red;
    logic [2:0]  s_white;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_q[$];
    logic [11:0] dut_q[$];
    bit          exp_solved;
    bit          hung = 0;

    always #5 clock = ~clock;

    mastermind_solver_if bus ();

    mastermind_solver #(.MAX_GUESSES(MAX_G), .INIT_GUESS(INIT)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .bus         (bus),
        .busy        (busy),
        .solved      (solved),
        .fail        (fail),
        .guess_count (guess_count)
    );

    mastermind_score u_unit (
        .a     (sa),
        .b     (sb),
        .red   (s_red),
        .white (s_white)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0o, expected %0o", name, act, exp);
        end
    endtask

    // Reference scorer: greedy pairing of leftover pegs after exact matches.
    function automatic void ref_score(input logic [11:0] a, input logic [11:0] b,
                                      output int r, output int w);
        int pa[4];
        int pb[4];
        bit hit_a[4];
        bit used_b[4];
        bit done;
        r = 0;
        w = 0;
        for (int i = 0; i < 4; i++) begin
            pa[i] = int'(a[3*i +: 3]);
            pb[i] = int'(b[3*i +: 3]);
            hit_a[i] = 0;
            used_b[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (pa[i] == pb[i]) begin
                r++;
                hit_a[i] = 1;
                used_b[i] = 1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            done = 0;
            if (!hit_a[i]) begin
                for (int j = 0; j < 4; j++) begin
                    if (!done && !used_b[j] && pa[i] == pb[j]) begin
                        used_b[j] = 1;
                        w++;
                        done = 1;
                    end
                end
            end
        end
    endfunction

    // Game model: predicts the full guess sequence and the outcome for a secret.
    task automatic model_game(input logic [11:0] secret);
        logic [11:0] hg[$];
        int          hr[$];
        int          hw[$];
        logic [11:0] g;
        int          ptr;
        int          r;
        int          w;
        int          cr;
        int          cw;
        bit          found;
        bit          ok;
        exp_q.delete();
        g   = INIT;
        ptr = 0;
        forever begin
            exp_q.push_back(g);
            ref_score(g, secret, r, w);
            hg.push_back(g);
            hr.push_back(r);
            hw.push_back(w);
            if (r == 4) begin
                exp_solved = 1;
                return;
            end
            if (hg.size() == MAX_G) begin
                exp_solved = 0;
                return;
            end
            found = 0;
            for (int c = ptr; c < 4096 && !found; c++) begin
                ok = 1;
                foreach (hg[k]) begin
                    ref_score(12'(c), hg[k], cr, cw);
                    if (cr != hr[k] || cw != hw[k]) ok = 0;
                end
                if (ok) begin
                    g     = 12'(c);
                    ptr   = c + 1;
                    found = 1;
                end
            end
            if (!found) begin
                exp_solved = 0;
                return;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int t = 0;
        while (!bus.guess_valid && t < 45000) begin
            @(negedge clock);
            t++;
        end
        ok = bus.guess_valid;
        check("offer_seen", 32'(ok), 1);
    endtask

    task automatic play_game(input logic [11:0] secret, input int max_bp);
        int r;
        int w;
        bit ok;
        model_game(secret);
        dut_q.delete();
        pulse_start();
        foreach (exp_q[k]) begin
            wait_valid(ok);
            if (!ok) begin
                hung = 1;
                do_reset();
                return;
            end
            check("guess", bus.guess, exp_q[k]);
            dut_q.push_back(bus.guess);
            repeat ($urandom_range(0, max_bp)) begin
                @(negedge clock);
                check("guess_hold", {bus.guess_valid, bus.guess}, {1'b1, exp_q[k]});
            end
            bus.guess_ready = 1'b1;
            @(negedge clock);
            bus.guess_ready = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clock);
            ref_score(dut_q[k], secret, r, w);
            bus.fb_valid = 1'b1;
            bus.fb_red   = 3'(r);
            bus.fb_white = 3'(w);
            @(negedge clock);
            bus.fb_valid = 1'b0;
        end
        check("end_solved", solved, exp_solved);
        check("end_fail", fail, !exp_solved);
        check("end_busy", busy, 0);
        check("end_count", guess_count, exp_q.size());
        check("end_count_limit", guess_count <= MAX_G, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        score_vec_t vecs[8];
        int r;
        int w;
        int cyc;

        bus.guess_ready = 1'b0;
        bus.fb_valid    = 1'b0;
        bus.fb_red      = '0;
        bus.fb_white    = '0;
        sa = '0;
        sb = '0;

        vecs[0] = '{12'o0011, 12'o1100, 3'd0, 3'd4};
        vecs[1] = '{12'o1234, 12'o1234, 3'd4, 3'd0};
        vecs[2] = '{12'o0000, 12'o0011, 3'd2, 3'd0};
        vecs[3] = '{12'o7000, 12'o0007, 3'd2, 3'd2};
        vecs[4] = '{12'o1234, 12'o5670, 3'd0, 3'd0};
        vecs[5] = '{12'o1122, 12'o1212, 3'd2, 3'd2};
        vecs[6] = '{12'o7777, 12'o7770, 3'd3, 3'd0};
        vecs[7] = '{12'o1230, 12'o0123, 3'd0, 3'd4};

        foreach (vecs[i]) begin
            sa = vecs[i].a;
            sb = vecs[i].b;
            #1;
            check("score_vec_red", s_red, vecs[i].red);
            check("score_vec_white", s_white, vecs[i].white);
        end
        for (int i = 0; i < 40; i++) begin
            sa = 12'($urandom_range(0, 4095));
            sb = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 4095)) : {sa[5:0], sa[11:6]};
            #1;
            ref_score(sa, sb, r, w);
            check("score_rand_red", s_red, r);
            check("score_rand_white", s_white, w);
        end

        // Outputs under reset.
        @(negedge clock);
        check("rst_guess", bus.guess, 0);
        check("rst_valid", bus.guess_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_solved", solved, 0);
        check("rst_fail", fail, 0);
        check("rst_count", guess_count, 0);
        reset = 1'b0;

        // Instant solve.
        play_game(12'o0011, 0);
        check("g1_first", (dut_q.size() > 0) ? dut_q[0] : 12'o7777, INIT);
        check("g1_count", guess_count, 1);
        check("g1_solved", solved, 1);
        check("g1_busy", busy, 0);

        // Two-step solve.
        play_game(12'o0000, 2);
        check("g2_second", (dut_q.size() == 2) ? dut_q[1] : 12'o7777, 12'o0000);
        check("g2_count", guess_count, 2);
        check("g2_solved", solved, 1);

        // Random games; most secrets kept low to bound search length.
        for (int g = 0; g < 100 && !hung; g++) play_game(12'($urandom_range(0, 12'o0377)), 5);
        for (int g = 0; g < 3 && !hung; g++) play_game(12'($urandom_range(0, 4095)), 5);

        // Feedback coinciding with acceptance is ignored; impossible total fails at once.
        pulse_start();
        check("inv_solved_cleared", solved, 0);
        check("inv_guess", bus.guess, INIT);
        bus.guess_ready = 1'b1;
        bus.fb_valid    = 1'b1;
        bus.fb_red      = 3'd4;
        bus.fb_white    = 3'd0;
        @(negedge clock);
        bus.guess_ready = 1'b0;
        bus.fb_valid    = 1'b0;
        check("same_cycle_fb_ignored", {solved, busy}, 2'b01);
        bus.fb_valid = 1'b1;
        bus.fb_red   = 3'd3;
        bus.fb_white = 3'd2;
        @(negedge clock);
        bus.fb_valid = 1'b0;
        check("sum_fail", fail, 1);
        check("sum_fail_busy", busy, 0);
        check("sum_fail_solved", solved, 0);

        // 3 red / 1 white is unattainable: every candidate is rejected.
        pulse_start();
        check("restart_count", guess_count, 0);
        check("restart_fail_cleared", fail, 0);
        bus.guess_ready = 1'b1;
        @(negedge clock);
        bus.guess_ready = 1'b0;
        bus.fb_valid = 1'b1;
        bus.fb_red   = 3'd3;
        bus.fb_white = 3'd1;
        @(negedge clock);
        bus.fb_valid = 1'b0;
        cyc = 0;
        while (!fail && cyc < 6000) begin
            @(negedge clock);
            cyc++;
        end
        check("exhaust_fail", fail, 1);
        check("exhaust_cycles", (cyc >= 4095 && cyc <= 4097), 1);
        check("exhaust_no_offer", bus.guess_valid, 0);

        // Asynchronous reset in the middle of a search.
        pulse_start();
        bus.guess_ready = 1'b1;
        @(negedge clock);
        bus.guess_ready = 1'b0;
        bus.fb_valid = 1'b1;
        bus.fb_red   = 3'd0;
        bus.fb_white = 3'd0;
        @(negedge clock);
        bus.fb_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_search_busy", {busy, bus.guess_valid}, 2'b10);
        #2 reset = 1'b1;
        #1;
        check("async_guess", bus.guess, 0);
        check("async_valid", bus.guess_valid, 0);
        check("async_busy", busy, 0);
        check("async_count", guess_count, 0);
        check("async_flags", {solved, fail}, 2'b00);
        @(negedge clock);
        reset = 1'b0;
        pulse_start();
        check("post_rst_valid", bus.guess_valid, 1);
        check("post_rst_guess", bus.guess, INIT);
        check("post_rst_count", guess_count, 0);
        check("post_rst_busy", busy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
